// File: rtl/decoder_3to8_reg.sv
// decoder_3to8_reg
//   Registered binary-to-one-hot decoder for control-path selects.
//   A registered IN_W-bit code drives exactly one of OUT_W lines one
//   clock after it is sampled with en=1. With en=0 the output returns
//   to the idle pattern. ACTIVE_LOW=1 inverts every output bit, so the
//   selected line is 0 and the idle lines are 1.
//
// Parameters
//   IN_W       width of the select code
//   OUT_W      output width, must equal 2**IN_W
//   ACTIVE_LOW 0: one-hot output, 1: one-cold output
//
// Ports
//   clk    rising-edge clock
//   rst    asynchronous active-high reset (out idle, valid low)
//   en     decode enable, sampled on rising clk
//   in     binary select code
//   out    registered one-hot / one-cold decode
//   valid  out holds the decode of an enabled sample
module decoder_3to8_reg #(
  parameter int IN_W       = 3,
  parameter int OUT_W      = 2 ** IN_W,
  parameter int ACTIVE_LOW = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [IN_W-1:0]   in,
  output logic [OUT_W-1:0]  out,
  output logic              valid
);

  generate
    if (OUT_W != 2 ** IN_W) begin : g_bad_width
      $error("decoder_3to8_reg: OUT_W must equal 2**IN_W");
    end
  endgenerate

  // Idle pattern doubles as the polarity mask: XOR with it turns the
  // one-hot decode into one-cold when ACTIVE_LOW is set.
  localparam logic [OUT_W-1:0] IDLE = (ACTIVE_LOW != 0) ? '1 : '0;

  logic [OUT_W-1:0] dec;

  always_comb begin
    dec = OUT_W'(1) << in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out   <= IDLE;
      valid <= 1'b0;
    end else if (en) begin
      out   <= dec ^ IDLE;
      valid <= 1'b1;
    end else begin
      out   <= IDLE;
      valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decoder_3to8_reg.sv
// tb_decoder_3to8_reg
//   Directed bench for decoder_3to8_reg: a default (one-hot) instance and
//   an ACTIVE_LOW=1 instance share the same stimulus. Outputs are checked
//   one clock after each sample, plus a one-hot/idle invariant on every
//   falling edge.
module tb_decoder_3to8_reg;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [2:0] in;
  logic [7:0] out;
  logic       valid;
  logic [7:0] out_al;
  logic       valid_al;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic        mon_on = 1'b0;

  always #5 clk = ~clk;

  decoder_3to8_reg #(.IN_W(3), .OUT_W(8), .ACTIVE_LOW(0)) dut (
    .clk(clk), .rst(rst), .en(en), .in(in), .out(out), .valid(valid)
  );

  decoder_3to8_reg #(.IN_W(3), .OUT_W(8), .ACTIVE_LOW(1)) dut_al (
    .clk(clk), .rst(rst), .en(en), .in(in), .out(out_al), .valid(valid_al)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Drive one sample on the falling edge, return just after the rising
  // edge that captures it.
  task automatic step(input logic e, input logic [2:0] code);
    @(negedge clk);
    en = e;
    in = code;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      if (valid === 1'b1) check("inv_pop", 8'($countones(out)), 8'd1);
      else                check("inv_idle", out, 8'h00);
      if (valid_al === 1'b1) check("inv_pop_al", 8'($countones(~out_al)), 8'd1);
      else                   check("inv_idle_al", out_al, 8'hFF);
    end
  end

  logic [2:0] sweep_in  [10] = '{3'b000, 3'b010, 3'b001, 3'b101, 3'b000,
                                 3'b010, 3'b011, 3'b100, 3'b000, 3'b110};
  logic [7:0] sweep_exp [10] = '{8'b0000_0001, 8'b0000_0100, 8'b0000_0010,
                                 8'b0010_0000, 8'b0000_0001, 8'b0000_0100,
                                 8'b0000_1000, 8'b0001_0000, 8'b0000_0001,
                                 8'b0100_0000};
  logic [7:0] exh_exp   [8]  = '{8'h01, 8'h02, 8'h04, 8'h08,
                                 8'h10, 8'h20, 8'h40, 8'h80};
  logic       gate_en   [3]  = '{1'b1, 1'b0, 1'b1};
  logic [7:0] gate_exp  [3]  = '{8'b0000_1000, 8'b0000_0000, 8'b0000_1000};

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    in  = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out", out, 8'h00);
    check("rst_valid", {7'b0, valid}, 8'h00);
    check("rst_out_al", out_al, 8'hFF);
    check("rst_valid_al", {7'b0, valid_al}, 8'h00);
    mon_on = 1'b1;

    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 3'b000);
    check("post_rst_idle", out, 8'h00);
    check("post_rst_valid", {7'b0, valid}, 8'h00);

    // async reset assertion with out = 0010_0000, mid-cycle
    step(1'b1, 3'b101);
    check("pre_rst_out", out, 8'b0010_0000);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_out", out, 8'h00);
    check("async_rst_valid", {7'b0, valid}, 8'h00);
    en  = 1'b0;
    rst = 1'b0;
    step(1'b0, 3'b101);
    check("rel_en0_out", out, 8'h00);
    check("rel_en0_valid", {7'b0, valid}, 8'h00);

    for (int i = 0; i < 10; i++) begin
      step(1'b1, sweep_in[i]);
      check($sformatf("sweep%0d_out", i), out, sweep_exp[i]);
      check($sformatf("sweep%0d_valid", i), {7'b0, valid}, 8'h01);
      if (sweep_in[i] == 3'b101) begin
        check("al_101_out", out_al, 8'b1101_1111);
        check("al_101_valid", {7'b0, valid_al}, 8'h01);
      end
    end

    for (int i = 0; i < 8; i++) begin
      step(1'b1, 3'(i));
      check($sformatf("exh%0d_out", i), out, exh_exp[i]);
      check($sformatf("exh%0d_valid", i), {7'b0, valid}, 8'h01);
    end

    // same code twice: output stays constant
    step(1'b1, 3'b111);
    check("repeat_out", out, 8'b1000_0000);
    check("repeat_valid", {7'b0, valid}, 8'h01);

    for (int i = 0; i < 3; i++) begin
      step(gate_en[i], 3'b011);
      check($sformatf("gate%0d_out", i), out, gate_exp[i]);
      check($sformatf("gate%0d_valid", i), {7'b0, valid}, {7'b0, gate_en[i]});
    end

    // short reset pulse in the middle of a running stream
    step(1'b1, 3'b010);
    check("ms_pre0_out", out, 8'b0000_0100);
    step(1'b1, 3'b110);
    check("ms_pre1_out", out, 8'b0100_0000);
    #1;
    rst = 1'b1;
    #1;
    check("ms_rst_out", out, 8'h00);
    check("ms_rst_valid", {7'b0, valid}, 8'h00);
    check("ms_rst_out_al", out_al, 8'hFF);
    #1;
    rst = 1'b0;
    step(1'b1, 3'b100);
    check("ms_fresh_out", out, 8'b0001_0000);
    check("ms_fresh_valid", {7'b0, valid}, 8'h01);
    check("ms_fresh_out_al", out_al, 8'b1110_1111);

    step(1'b0, 3'b100);
    mon_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish (t=%0t)", $time);
    $fatal(1, "timeout");
  end

endmodule
